// File: rtl/store_align_unit.sv
// store_align_unit: write-side alignment for the data-memory bus.
//
// Accepts one store (address, LSB-justified data, byte-enable size code)
// from the MEM stage, shifts data and strobes into 8-byte-aligned bus
// beats, and issues one beat, or two when the store crosses an 8-byte
// boundary. Each beat is a valid/ready request followed by a write
// acknowledge on mem_resp_valid. The pipeline is stalled until the store
// completes (st_done) or fails (st_err: illegal size code or timeout).
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   st_valid/st_ready     store request handshake from the MEM stage
//   st_addr/st_data       byte address and LSB-justified store data
//   st_byte_enable        size code 8'h01, 8'h03, 8'h0F or 8'hFF
//   st_stall              pipeline hold while the store is in flight
//   st_done/st_err        one-cycle completion / error pulses
//   mem_req_*             aligned bus write request (addr, wdata, wstrb)
//   mem_resp_valid        bus write acknowledge
//
// TIMEOUT_CYCLES must be below 2**CNT_W; 0 disables the timeout.

module store_align_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [63:0] st_addr,
    input  logic [63:0] st_data,
    input  logic [7:0]  st_byte_enable,
    output logic        st_ready,
    output logic        st_stall,
    output logic        st_done,
    output logic        st_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_req_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wstrb,
    input  logic        mem_resp_valid
);

    // StErr is a single non-bus cycle that reports an illegal size code.
    // It keeps st_ready low so the still-asserted request is not re-accepted.
    typedef enum logic [2:0] {
        StIdle,
        StReq0,
        StWait0,
        StReq1,
        StWait1,
        StErr
    } state_t;

    state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]   off_q;
    logic [60:0]  base_q;   // st_addr[63:3]; beat address is {base, 3'b0}
    logic [63:0]  data_q;
    logic [7:0]   be_q;

    logic         accept;
    logic         legal_be;
    logic [15:0]  strb16;
    logic [127:0] data128;
    logic         split;
    logic         limit_hit;

    assign accept   = st_valid && (state_q == StIdle);
    assign legal_be = (st_byte_enable == 8'h01) || (st_byte_enable == 8'h03) ||
                      (st_byte_enable == 8'h0F) || (st_byte_enable == 8'hFF);

    assign strb16  = {8'b0, be_q} << off_q;
    assign data128 = {64'b0, data_q} << {off_q, 3'b000};
    assign split   = |strb16[15:8];

    assign limit_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            off_q   <= '0;
            base_q  <= '0;
            data_q  <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                off_q  <= st_addr[2:0];
                base_q <= st_addr[63:3];
                data_q <= st_data;
                be_q   <= st_byte_enable;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        st_ready      = 1'b0;
        st_stall      = 1'b0;
        st_done       = 1'b0;
        st_err        = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        mem_wdata     = '0;
        mem_wstrb     = '0;

        unique case (state_q)
            StIdle: begin
                st_ready = 1'b1;
                if (st_valid) begin
                    state_d = legal_be ? StReq0 : StErr;
                end
            end
            StErr: begin
                st_err  = 1'b1;
                state_d = StIdle;
            end
            StReq0: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {base_q, 3'b000};
                mem_wdata     = data128[63:0];
                mem_wstrb     = strb16[7:0];
                if (mem_req_ready) begin
                    state_d = StWait0;
                    cnt_d   = '0;
                end
            end
            StWait0: begin
                cnt_d = cnt_q + 1'b1;
                // A response on the limit cycle still counts as success.
                if (mem_resp_valid) begin
                    if (split) begin
                        state_d = StReq1;
                    end else begin
                        state_d = StIdle;
                        st_done = 1'b1;
                    end
                end else if (limit_hit) begin
                    state_d = StIdle;
                    st_err  = 1'b1;
                end
            end
            StReq1: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {base_q + 61'd1, 3'b000};
                mem_wdata     = data128[127:64];
                mem_wstrb     = strb16[15:8];
                if (mem_req_ready) begin
                    state_d = StWait1;
                    cnt_d   = '0;
                end
            end
            StWait1: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_resp_valid) begin
                    state_d = StIdle;
                    st_done = 1'b1;
                end else if (limit_hit) begin
                    state_d = StIdle;
                    st_err  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Hold the pipeline from acceptance until the completing cycle.
        st_stall = st_valid && ((state_q != StIdle) || accept) && !st_done && !st_err;

        // Outputs read as zero while reset is asserted.
        if (reset) begin
            st_ready      = 1'b0;
            st_stall      = 1'b0;
            st_done       = 1'b0;
            st_err        = 1'b0;
            mem_req_valid = 1'b0;
            mem_req_addr  = '0;
            mem_wdata     = '0;
            mem_wstrb     = '0;
        end
    end

endmodule

// File: tb/tb_store_align_unit.sv
module tb_store_align_unit;

    localparam int unsigned TO = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        st_valid;
    logic [63:0] st_addr;
    logic [63:0] st_data;
    logic [7:0]  st_byte_enable;
    logic        st_ready;
    logic        st_stall;
    logic        st_done;
    logic        st_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_resp_valid;

    always #5 clock = ~clock;

    store_align_unit #(
        .TIMEOUT_CYCLES(TO),
        .CNT_W         (8)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .st_valid      (st_valid),
        .st_addr       (st_addr),
        .st_data       (st_data),
        .st_byte_enable(st_byte_enable),
        .st_ready      (st_ready),
        .st_stall      (st_stall),
        .st_done       (st_done),
        .st_err        (st_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_resp_valid(mem_resp_valid)
    );

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } beat_t;

    beat_t beat_q[$];
    int    out_q[$];   // 0 = done, 1 = err
    int    total = 0;
    int    bad   = 0;

    task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int size_of(input logic [7:0] be);
        case (be)
            8'h01:   return 1;
            8'h03:   return 2;
            8'h0F:   return 4;
            8'hFF:   return 8;
            default: return 0;
        endcase
    endfunction

    // Monitor: pops expected beats/outcomes whenever the DUT presents them.
    initial begin
        beat_t prev;
        beat_t cur;
        beat_t e;
        logic  prev_hold;
        int    o;
        prev_hold = 1'b0;
        prev      = '0;
        forever begin
            @(negedge clock);
            cur = '{addr: mem_req_addr, wdata: mem_wdata, wstrb: mem_wstrb};
            if (reset) begin
                check("reset_outputs", {st_ready, st_stall, st_done, st_err, mem_req_valid,
                                        mem_req_addr, mem_wdata, mem_wstrb}, '0);
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("hold_valid", mem_req_valid, 1'b1);
                    check("hold_beat", cur, prev);
                end
                if (!mem_req_valid) check("idle_bus_zero", {mem_wdata, mem_wstrb}, '0);
                if (mem_req_valid && mem_req_ready) begin
                    if (beat_q.size() == 0) begin
                        check("unexpected_beat", cur, '0);
                    end else begin
                        e = beat_q.pop_front();
                        check("beat", cur, e);
                    end
                end
                prev_hold = mem_req_valid && !mem_req_ready;
                prev      = cur;
                if (st_done || st_err) begin
                    if (out_q.size() == 0) begin
                        check("unexpected_end", {st_done, st_err}, 2'b00);
                    end else begin
                        o = out_q.pop_front();
                        check("outcome", {st_done, st_err}, (o == 1) ? 2'b01 : 2'b10);
                    end
                end
            end
        end
    end

    // Issues one store, plays the bus side, and checks handshake timing.
    task automatic run_store(input logic [63:0] addr, input logic [63:0] data,
                             input logic [7:0] be, input int r, input int s,
                             input bit respond, input bit rst_w1);
        int    sz;
        int    off;
        bit    split;
        int    exp_cyc;
        int    end_cyc;
        int    cyc;
        int    hs;
        int    rcnt;
        int    wcnt;
        bit    waiting;
        bit    fin;
        bit    did_rst;
        bit    is_end;
        beat_t b0;
        beat_t b1;
        logic [7:0] bytes [16];
        logic       strb  [16];

        sz    = size_of(be);
        off   = int'(addr[2:0]);
        split = (sz != 0) && (off + sz > 8);
        for (int p = 0; p < 16; p++) begin
            int k;
            k        = p - off;
            bytes[p] = (k >= 0 && k < 8) ? data[k*8 +: 8] : 8'h00;
            strb[p]  = (k >= 0 && k < sz);
        end
        b0.addr = {addr[63:3], 3'b000};
        b1.addr = b0.addr + 64'd8;
        for (int p = 0; p < 8; p++) begin
            b0.wdata[p*8 +: 8] = bytes[p];
            b0.wstrb[p]        = strb[p];
            b1.wdata[p*8 +: 8] = bytes[p+8];
            b1.wstrb[p]        = strb[p+8];
        end

        exp_cyc = -1;
        if (sz == 0) begin
            out_q.push_back(1);
            exp_cyc = 1;
        end else begin
            beat_q.push_back(b0);
            if (!respond) begin
                out_q.push_back(1);
                exp_cyc = 2 + r + TO;
            end else if (split) begin
                beat_q.push_back(b1);
                if (!rst_w1) begin
                    out_q.push_back(0);
                    exp_cyc = 4 + 2*r + 2*s;
                end
            end else begin
                out_q.push_back(0);
                exp_cyc = 2 + r + s;
            end
        end

        st_valid       = 1'b1;
        st_addr        = addr;
        st_data        = data;
        st_byte_enable = be;
        hs = 0; rcnt = 0; wcnt = 0; waiting = 0; fin = 0; did_rst = 0; cyc = 0; end_cyc = -1;

        while (!fin && cyc < 200) begin
            if (waiting) begin
                mem_req_ready  = 1'b0;
                mem_resp_valid = respond && !(rst_w1 && hs == 2) && (wcnt == s);
                wcnt++;
            end else begin
                // Stray acknowledges outside WAIT must be ignored.
                mem_resp_valid = 1'($urandom_range(0, 1));
                if (mem_req_valid) begin
                    mem_req_ready = (rcnt >= r);
                    rcnt++;
                end else begin
                    mem_req_ready = 1'($urandom_range(0, 1));
                end
            end
            @(negedge clock);
            is_end = st_done || st_err;
            if (cyc == 0) check("st_ready_idle", st_ready, 1'b1);
            else          check("st_ready_busy", st_ready, 1'b0);
            check("st_stall", st_stall, !is_end);
            if (sz == 0) check("illegal_no_req", mem_req_valid, 1'b0);
            if (mem_req_valid && mem_req_ready) begin
                hs++;
                waiting = 1; wcnt = 0; rcnt = 0;
            end else if (waiting && mem_resp_valid) begin
                waiting = 0;
            end
            if (is_end) begin
                fin     = 1;
                end_cyc = cyc;
            end
            @(posedge clock);
            #1;
            cyc++;
            if (!fin && rst_w1 && hs == 2 && waiting && wcnt == 1) begin
                reset          = 1'b1;
                st_valid       = 1'b0;
                mem_req_ready  = 1'b0;
                mem_resp_valid = 1'b0;
                repeat (2) begin
                    @(posedge clock);
                    #1;
                end
                reset          = 1'b0;
                mem_resp_valid = 1'b1;   // late acknowledge for the aborted beat
                @(negedge clock);
                check("post_reset_req", mem_req_valid, 1'b0);
                check("post_reset_end", {st_done, st_err}, 2'b00);
                check("post_reset_ready", st_ready, 1'b1);
                @(posedge clock);
                #1;
                fin     = 1;
                did_rst = 1;
            end
        end

        if (!fin) check("store_cycle_budget", 1'b0, 1'b1);
        else if (!did_rst) check("latency", end_cyc, exp_cyc);
        st_valid       = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] be;
        logic [7:0] legal_tab [4];
        legal_tab[0] = 8'h01; legal_tab[1] = 8'h03; legal_tab[2] = 8'h0F; legal_tab[3] = 8'hFF;

        reset          = 1'b1;
        st_valid       = 1'b0;
        st_addr        = '0;
        st_data        = '0;
        st_byte_enable = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        run_store(64'h8000_0000, 64'h1122_3344_5566_7788, 8'hFF, 0, 0, 1, 0);
        run_store(64'h8000_0005, 64'h0000_0000_0000_00AB, 8'h01, 0, 1, 1, 0);
        run_store(64'h8000_0006, 64'h0000_0000_DEAD_BEEF, 8'h0F, 1, 1, 1, 0);
        run_store(64'h8000_0006, 64'h0000_0000_DEAD_BEEF, 8'h0F, 4, 2, 1, 0);
        run_store(64'h0000_1000, 64'hCAFE_F00D_1234_5678, 8'hFF, 0, 0, 0, 0);
        run_store(64'h0000_1006, 64'h0000_0000_A5A5_5A5A, 8'h0F, 1, 0, 0, 0);
        run_store(64'h0000_2003, 64'h0000_0000_0000_BEEF, 8'h03, 0, TO, 1, 0);
        run_store(64'h0000_3000, 64'h0000_0000_0000_1234, 8'h07, 0, 0, 1, 0);
        run_store(64'h8000_0006, 64'h0000_0000_DEAD_BEEF, 8'h0F, 0, 0, 1, 1);
        run_store(64'h8000_0007, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 0, 1, 0);

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) == 9) begin
                be = 8'($urandom);
                while (size_of(be) != 0) be = 8'($urandom);
            end else begin
                be = legal_tab[$urandom_range(0, 3)];
            end
            run_store({$urandom, $urandom}, {$urandom, $urandom}, be,
                      $urandom_range(0, 2), $urandom_range(0, 3),
                      ($urandom_range(0, 9) != 0), 0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock);
                #1;
            end
        end

        repeat (2) @(posedge clock);
        #1;
        check("beats_left", beat_q.size(), 0);
        check("outcomes_left", out_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
